// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Read-after-write hazard tracker sitting between decode (ID) and the
// 4x16b register file. Each in-flight register write is carried through a
// small shift pipe (EX .. WB). A decoding instruction that sources a
// register with a pending write raises stall. Every entry leaving WB is
// cross-checked against the RF write port, and any disagreement latches
// sb_error until reset.
//
// Optional build macro: RF_WB_BYPASS_EN
//   defined   -> the RF forwards write data to same-cycle reads, so the WB
//                stage is left out of pending/hazard.
//   undefined -> the WB stage counts as pending (RF returns old data).
module hazard_scoreboard #(
  parameter int  PIPE_DEPTH = 3,
  parameter int  REG_ADDR_W = 2,
  localparam int NUM_REGS   = 1 << REG_ADDR_W,
  localparam int CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_rs_used,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_wr,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  pipe_hold,
  input  logic [PIPE_DEPTH-1:0] flush_mask,
  input  logic                  wb_write,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending,
  output logic [CNT_W-1:0]      inflight_cnt,
  output logic                  sb_error
);

`ifdef RF_WB_BYPASS_EN
  // WB data is forwarded by the RF, so only stages before WB can hazard.
  localparam int CHK_STAGES = PIPE_DEPTH - 1;
`else
  // The RF returns stale data during the write cycle, so WB still hazards.
  localparam int CHK_STAGES = PIPE_DEPTH;
`endif

  localparam int LAST = PIPE_DEPTH - 1;

  // Pipe state: stage 0 = EX, stage LAST = WB.
  logic [PIPE_DEPTH-1:0] r_v;
  logic [REG_ADDR_W-1:0] r_rd [PIPE_DEPTH];
  logic                  r_error;

  logic [PIPE_DEPTH-1:0] w_v_next;
  logic [REG_ADDR_W-1:0] w_rd_next [PIPE_DEPTH];
  logic [NUM_REGS-1:0]   w_stage_hot [PIPE_DEPTH];
  logic [NUM_REGS-1:0]   w_pending;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_hazard;
  logic                  w_issue;
  logic                  w_retire_err;

  // Per-stage one-hot of the destination register, masked to checked stages.
  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
    if (gi < CHK_STAGES) begin : g_chk
      assign w_stage_hot[gi] = r_v[gi] ? (NUM_REGS'(1) << r_rd[gi]) : '0;
    end else begin : g_nochk
      assign w_stage_hot[gi] = '0;
    end
  end

  // Pending vector is the OR of all checked stage decodes.
  always_comb begin
    w_pending = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_pending = w_pending | w_stage_hot[k];
    end
  end

  // Occupancy counts every valid stage, including WB in both builds.
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_cnt = w_cnt + CNT_W'(r_v[k]);
    end
  end

  // Hazard detection and issue qualification. Stall is deliberately not
  // gated by pipe_hold; the pipe controller combines the two itself.
  always_comb begin
    w_hazard = id_valid & ((id_rs_used & w_pending[id_rs]) |
                           (id_rt_used & w_pending[id_rt]));
    w_issue  = id_valid & ~w_hazard & ~pipe_hold;
  end

  // Next pipe contents: shift (or hold), then apply flush to the
  // destination stages so flush wins over hold.
  always_comb begin
    w_v_next = r_v;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_rd_next[k] = r_rd[k];
    end
    if (!pipe_hold) begin
      w_v_next[0]  = w_issue & id_wr;
      w_rd_next[0] = id_rd;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        w_v_next[k]  = r_v[k-1];
        w_rd_next[k] = r_rd[k-1];
      end
    end
    w_v_next = w_v_next & ~flush_mask;
  end

  // Retire check on the WB entry as it stands before the shift; skipped
  // while the pipe is frozen because nothing retires then.
  always_comb begin
    if (r_v[LAST]) begin
      w_retire_err = ~pipe_hold & (~wb_write | (wb_addr != r_rd[LAST]));
    end else begin
      w_retire_err = ~pipe_hold & wb_write;
    end
  end

  // State update; reset discards every in-flight entry and the error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v     <= '0;
      r_rd    <= '{default: '0};
      r_error <= 1'b0;
    end else begin
      r_v  <= w_v_next;
      r_rd <= w_rd_next;
      if (w_retire_err) begin
        r_error <= 1'b1;
      end
    end
  end

  assign stall        = w_hazard;
  assign pending      = w_pending;
  assign inflight_cnt = w_cnt;
  assign sb_error     = r_error;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Inputs change 1 time unit after the
// rising edge; outputs are compared on the falling edge.
module tb_hazard_scoreboard;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs_used, id_rt_used, id_wr;
  logic [1:0] id_rs, id_rt, id_rd;
  logic       pipe_hold;
  logic [2:0] flush_mask;
  logic       wb_write;
  logic [1:0] wb_addr;
  logic       stall;
  logic [3:0] pending;
  logic [1:0] inflight_cnt;
  logic       sb_error;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_scoreboard #(.PIPE_DEPTH(3), .REG_ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rs(id_rs),
    .id_rt_used(id_rt_used), .id_rt(id_rt), .id_wr(id_wr), .id_rd(id_rd),
    .pipe_hold(pipe_hold), .flush_mask(flush_mask),
    .wb_write(wb_write), .wb_addr(wb_addr),
    .stall(stall), .pending(pending), .inflight_cnt(inflight_cnt),
    .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs_used = 0; id_rs = 0; id_rt_used = 0; id_rt = 0;
    id_wr = 0; id_rd = 0; pipe_hold = 0; flush_mask = 0;
    wb_write = 0; wb_addr = 0;
  endtask

  task automatic issue_wr(input logic [1:0] rd);
    id_valid = 1; id_wr = 1; id_rd = rd;
  endtask

  task automatic edge_t();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // 1. Reset with a reader of r1 presented
    idle(); reset = 1; id_valid = 1; id_rs_used = 1; id_rs = 1;
    edge_t(); edge_t();
    mid();
    chk("rst_stall", stall, 0);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_cnt", inflight_cnt, 0);
    chk("rst_err", sb_error, 0);
    edge_t();
    reset = 0; idle();
    edge_t();

    // 2. RAW hazard: writer of r1, then a reader of r1
    issue_wr(1);
    mid(); chk("raw_t0_stall", stall, 0);
    edge_t();
    id_wr = 0; id_rs_used = 1; id_rs = 1;
    mid(); chk("raw_t1_stall", stall, 1);
    chk("raw_t1_pend", pending, 4'b0010);
    chk("raw_t1_cnt", inflight_cnt, 1);
    edge_t();
    mid(); chk("raw_t2_stall", stall, 1);
    edge_t();
    wb_write = 1; wb_addr = 1;
    mid(); chk("raw_t3_stall", stall, BYP ? 0 : 1);
    edge_t();
    wb_write = 0;
    mid(); chk("raw_t4_stall", stall, 0);
    chk("raw_t4_cnt", inflight_cnt, 0);
    chk("raw_t4_err", sb_error, 0);
    edge_t();
    idle();

    // 3. Independent writers r2, r3, r0, r1; unused source never stalls
    issue_wr(2); id_rs = 2;
    mid(); chk("ind_u0_stall", stall, 0);
    edge_t();
    id_rd = 3;
    mid(); chk("ind_u1_stall", stall, 0); chk("ind_u1_cnt", inflight_cnt, 1);
    edge_t();
    id_rd = 0;
    mid(); chk("ind_u2_stall", stall, 0); chk("ind_u2_cnt", inflight_cnt, 2);
    edge_t();
    id_rd = 1; wb_write = 1; wb_addr = 2;
    mid(); chk("ind_u3_stall", stall, 0); chk("ind_u3_cnt", inflight_cnt, 3);
    chk("ind_u3_pend", pending, BYP ? 4'b1001 : 4'b1101);
    edge_t();
    id_valid = 0; id_wr = 0; wb_addr = 3;
    mid(); chk("ind_u4_cnt", inflight_cnt, 3);
    edge_t();
    wb_addr = 0;
    mid(); chk("ind_u5_cnt", inflight_cnt, 2);
    edge_t();
    wb_addr = 1;
    mid(); chk("ind_u6_cnt", inflight_cnt, 1);
    edge_t();
    wb_write = 0; wb_addr = 0;
    mid(); chk("ind_u7_cnt", inflight_cnt, 0);
    chk("ind_u7_pend", pending, 4'b0000); chk("ind_u7_err", sb_error, 0);
    edge_t();

    // 4. Flush: r1 flushed as it lands in stage 1, reader must not stall
    issue_wr(1);
    edge_t();
    idle(); flush_mask = 3'b010;
    mid(); chk("fl_f1_pend", pending, 4'b0010); chk("fl_f1_cnt", inflight_cnt, 1);
    edge_t();
    flush_mask = 0; id_valid = 1; id_rs_used = 1; id_rs = 1;
    mid(); chk("fl_f2_stall", stall, 0); chk("fl_f2_cnt", inflight_cnt, 0);
    edge_t();
    idle();
    edge_t();
    mid(); chk("fl_f4_err", sb_error, 0);
    // flush of the entry entering EX in its issue cycle
    issue_wr(2); flush_mask = 3'b001;
    edge_t();
    idle();
    mid(); chk("fl_g1_cnt", inflight_cnt, 0);
    edge_t();

    // 5. Hold: r2 in EX, frozen 4 cycles with a reader on rt and a stray wb strobe
    issue_wr(2);
    edge_t();
    id_wr = 0; id_rd = 0; id_rt_used = 1; id_rt = 2;
    pipe_hold = 1; wb_write = 1; wb_addr = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("hold%0d_stall", i), stall, 1);
      chk($sformatf("hold%0d_pend", i), pending, 4'b0100);
      chk($sformatf("hold%0d_cnt", i), inflight_cnt, 1);
      edge_t();
    end
    pipe_hold = 0; wb_write = 0;
    mid(); chk("hold_h5_stall", stall, 1); chk("hold_h5_err", sb_error, 0);
    edge_t();
    mid(); chk("hold_h6_stall", stall, 1);
    edge_t();
    wb_write = 1; wb_addr = 2;
    mid(); chk("hold_h7_stall", stall, BYP ? 0 : 1);
    edge_t();
    wb_write = 0; wb_addr = 0;
    mid(); chk("hold_h8_stall", stall, 0); chk("hold_h8_cnt", inflight_cnt, 0);
    chk("hold_h8_err", sb_error, 0);
    edge_t();
    idle();

    // Flush has priority over hold
    issue_wr(3);
    edge_t();
    idle(); pipe_hold = 1; flush_mask = 3'b001;
    mid(); chk("fh_k1_cnt", inflight_cnt, 1);
    edge_t();
    idle();
    mid(); chk("fh_k2_cnt", inflight_cnt, 0); chk("fh_k2_pend", pending, 4'b0000);
    edge_t();

    // Issue and retire of r1 in the same cycle keeps r1 pending
    issue_wr(1);
    edge_t();
    idle();
    edge_t(); edge_t();
    issue_wr(1); wb_write = 1; wb_addr = 1;
    mid(); chk("ir_a3_stall", stall, 0);
    chk("ir_a3_pend", pending, BYP ? 4'b0000 : 4'b0010);
    edge_t();
    idle();
    mid(); chk("ir_a4_pend", pending, 4'b0010); chk("ir_a4_cnt", inflight_cnt, 1);
    edge_t(); edge_t();
    wb_write = 1; wb_addr = 1;
    edge_t();
    idle();
    mid(); chk("ir_a7_cnt", inflight_cnt, 0); chk("ir_a7_err", sb_error, 0);
    edge_t();

    // 6. Mismatch: WB holds r3 but the RF writes r2
    issue_wr(3);
    edge_t();
    idle();
    edge_t(); edge_t();
    wb_write = 1; wb_addr = 2;
    mid(); chk("mm_m3_err", sb_error, 0);
    edge_t();
    wb_write = 0; wb_addr = 0; issue_wr(0);
    mid(); chk("mm_m4_err", sb_error, 1);
    edge_t();
    id_wr = 0; id_rd = 0; id_rs_used = 1; id_rs = 0;
    mid(); chk("mm_m5_stall", stall, 1); chk("mm_m5_err", sb_error, 1);
    reset = 1;
    edge_t();
    reset = 0;
    mid(); chk("mm_m6_stall", stall, 0); chk("mm_m6_cnt", inflight_cnt, 0);
    chk("mm_m6_pend", pending, 4'b0000); chk("mm_m6_err", sb_error, 0);
    edge_t();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
